corereset_pf: RTL and testbench

PolarFire fabric reset controller. It merges the external reset, PLL lock, device init-done, I/O bank supply status, power-on reset, system-services busy and Flash*Freeze restore into one fabric reset, FABRIC_RESET_N. FABRIC_RESET_N asserts asynchronously and releases synchronously to CLK. It also drives the combinational PLL power-down control, PLL_POWERDOWN_B. Sits between the clock/power infrastructure and all fabric logic on the CLK domain.

---
 rtl/corereset_pf_reset_sync_n.sv | 25 ++
 rtl/corereset_pf.sv | 44 ++++
 tb/tb_corereset_pf.sv | 325 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/corereset_pf_reset_sync_n.sv
// Generic reset synchronizer: asserts asynchronously with arst_n, releases
// STAGES rising clk edges after arst_n goes high.
module reset_sync_n #(
    parameter int STAGES = 3
) (
    input  logic clk,
    input  logic arst_n,
    output logic rst_n_out
);

    logic [STAGES-1:0] sync_p0;

    // A 1 walks up the chain; any low on arst_n wipes every stage at once,
    // so a narrow pulse always costs a full resynchronization.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            sync_p0 <= '0;
        end else begin
            sync_p0 <= {sync_p0[STAGES-2:0], 1'b1};
        end
    end

    assign rst_n_out = sync_p0[STAGES-1];

endmodule

// File: rtl/corereset_pf.sv
// PolarFire fabric reset controller: merges all reset sources into one
// async-assert / sync-release fabric reset and drives PLL power-down.
module corereset_pf #(
    parameter int SYNC_STAGES = 3,
    parameter int USE_BANK_X  = 1,
    parameter int USE_BANK_Y  = 1
) (
    input  logic CLK,
    input  logic EXT_RST_N,
    input  logic PLL_LOCK,
    input  logic BANK_x_VDDI_STATUS,
    input  logic BANK_y_VDDI_STATUS,
    input  logic FPGA_POR_N,
    input  logic SS_BUSY,
    input  logic INIT_DONE,
    input  logic FF_US_RESTORE,
    output logic FABRIC_RESET_N,
    output logic PLL_POWERDOWN_B
);

    logic bank_x_ok;
    logic bank_y_ok;
    logic pwr_ok;
    logic rst_req_n;

    // A disabled bank is treated as permanently good.
    assign bank_x_ok = BANK_x_VDDI_STATUS | (USE_BANK_X == 0);
    assign bank_y_ok = BANK_y_VDDI_STATUS | (USE_BANK_Y == 0);
    assign pwr_ok    = FPGA_POR_N & bank_x_ok & bank_y_ok;

    assign PLL_POWERDOWN_B = pwr_ok;

    assign rst_req_n = EXT_RST_N & PLL_LOCK & INIT_DONE & pwr_ok
                     & ~SS_BUSY & ~FF_US_RESTORE;

    reset_sync_n #(
        .STAGES(SYNC_STAGES)
    ) u_reset_sync (
        .clk      (CLK),
        .arst_n   (rst_req_n),
        .rst_n_out(FABRIC_RESET_N)
    );

endmodule

// File: tb/tb_corereset_pf.sv
// Bench for corereset_pf: default, bank-y-ignored and 5-stage instances
// driven from shared inputs and compared against an edge-counting model.
module tb_corereset_pf;

    logic CLK = 1'b0;
    logic clk_en = 1'b1;
    logic ext = 1'b0, lock = 1'b1, bx = 1'b1, by = 1'b1;
    logic por = 1'b1, ss = 1'b0, init = 1'b1, ff = 1'b0;
    logic fab_a, pll_a, fab_b, pll_b, fab_c, pll_c;

    int errors = 0;
    int checks = 0;
    int neg_a = 0;
    int neg_c = 0;
    int cnt = 0;

    corereset_pf u_a (
        .CLK(CLK), .EXT_RST_N(ext), .PLL_LOCK(lock), .BANK_x_VDDI_STATUS(bx),
        .BANK_y_VDDI_STATUS(by), .FPGA_POR_N(por), .SS_BUSY(ss), .INIT_DONE(init),
        .FF_US_RESTORE(ff), .FABRIC_RESET_N(fab_a), .PLL_POWERDOWN_B(pll_a));

    corereset_pf #(.USE_BANK_Y(0)) u_b (
        .CLK(CLK), .EXT_RST_N(ext), .PLL_LOCK(lock), .BANK_x_VDDI_STATUS(bx),
        .BANK_y_VDDI_STATUS(by), .FPGA_POR_N(por), .SS_BUSY(ss), .INIT_DONE(init),
        .FF_US_RESTORE(ff), .FABRIC_RESET_N(fab_b), .PLL_POWERDOWN_B(pll_b));

    corereset_pf #(.SYNC_STAGES(5)) u_c (
        .CLK(CLK), .EXT_RST_N(ext), .PLL_LOCK(lock), .BANK_x_VDDI_STATUS(bx),
        .BANK_y_VDDI_STATUS(by), .FPGA_POR_N(por), .SS_BUSY(ss), .INIT_DONE(init),
        .FF_US_RESTORE(ff), .FABRIC_RESET_N(fab_c), .PLL_POWERDOWN_B(pll_c));

    initial forever begin
        #5;
        if (clk_en) CLK = ~CLK;
    end

    // Reference: reset is requested while any condition is bad; fabric is
    // released once that many clean rising edges have been seen.
    logic m_pwr, m_pwr_noy, m_req;
    assign m_pwr     = por & bx & by;
    assign m_pwr_noy = por & bx;
    assign m_req     = ext & lock & init & m_pwr & !ss & !ff;

    always @(m_req) if (!m_req) cnt = 0;
    always @(posedge CLK) if (m_req && cnt < 1000) cnt = cnt + 1;

    always @(negedge fab_a) neg_a++;
    always @(negedge fab_c) neg_c++;

    task automatic all_good();
        ext = 1; lock = 1; bx = 1; by = 1; por = 1; ss = 0; init = 1; ff = 0;
    endtask

    task automatic set_cond(input int which, input bit bad);
        case (which)
            0: ext  = !bad;
            1: lock = !bad;
            2: init = !bad;
            3: ss   = bad;
            4: ff   = bad;
            default: por = !bad;
        endcase
    endtask

    task automatic settle_released();
        @(negedge CLK);
        all_good();
        repeat (6) @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (fab_a !== 1'b0 || fab_c !== 1'b0) begin
            errors++;
            $display("FAIL reset_por: fab_a=%b fab_c=%b expected 0", fab_a, fab_c);
        end
        repeat (4) @(posedge CLK);
        #1;
        checks++;
        if (fab_a !== 1'b0) begin
            errors++;
            $display("FAIL reset_held: fab_a=%b expected 0", fab_a);
        end
        @(negedge CLK);
        all_good();
        begin
            int n;
            n = 0;
            for (int i = 1; i <= 16; i++) begin
                @(posedge CLK); #1;
                if (fab_a === 1'b1) begin n = i; break; end
            end
            checks++;
            if (n != 3) begin
                errors++;
                $display("FAIL reset_release_edges: got=%0d expected 3", n);
            end
        end
    endtask

    task automatic test_async_assert(input int which);
        settle_released();
        @(negedge CLK);
        clk_en = 0;
        #3;
        set_cond(which, 1'b1);
        #1;
        checks++;
        if (fab_a !== 1'b0 || fab_c !== 1'b0) begin
            errors++;
            $display("FAIL async_assert[%0d]: fab_a=%b fab_c=%b expected 0", which, fab_a, fab_c);
        end
        #2;
        set_cond(which, 1'b0);
        #1;
        checks++;
        if (fab_a !== 1'b0) begin
            errors++;
            $display("FAIL stopped_clk_hold[%0d]: fab_a=%b expected 0", which, fab_a);
        end
        clk_en = 1;
        for (int e = 1; e <= 3; e++) begin
            @(posedge CLK); #1;
            checks++;
            if (fab_a !== (e >= 3)) begin
                errors++;
                $display("FAIL release[%0d] edge %0d: fab_a=%b expected %b", which, e, fab_a, e >= 3);
            end
        end
    endtask

    task automatic test_hold();
        bit seen_high;
        for (int w = 3; w <= 4; w++) begin
            settle_released();
            @(negedge CLK);
            set_cond(w, 1'b1);
            seen_high = 0;
            repeat (20) begin
                @(posedge CLK); #1;
                if (fab_a !== 1'b0) seen_high = 1;
            end
            checks++;
            if (seen_high) begin
                errors++;
                $display("FAIL hold[%0d]: fab_a went high while held, expected 0", w);
            end
            @(negedge CLK);
            set_cond(w, 1'b0);
            for (int e = 1; e <= 3; e++) begin
                @(posedge CLK); #1;
                checks++;
                if (fab_a !== (e >= 3)) begin
                    errors++;
                    $display("FAIL hold_release[%0d] edge %0d: fab_a=%b expected %b", w, e, fab_a, e >= 3);
                end
            end
        end
        // Both held: releases only after the last one clears
        @(negedge CLK);
        ss = 1; ff = 1;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        ss = 0;
        repeat (5) @(posedge CLK);
        #1;
        checks++;
        if (fab_a !== 1'b0) begin
            errors++;
            $display("FAIL multi_hold: fab_a=%b expected 0", fab_a);
        end
        @(negedge CLK);
        ff = 0;
        repeat (3) @(posedge CLK);
        #1;
        checks++;
        if (fab_a !== 1'b1) begin
            errors++;
            $display("FAIL multi_release: fab_a=%b expected 1", fab_a);
        end
    endtask

    task automatic test_pll();
        // columns: bx, by, por, expected pll_a, expected pll_b (bank y ignored)
        logic [4:0] tbl [8];
        tbl[0] = 5'b1_0_0_0_0;
        tbl[1] = 5'b1_1_0_0_0;
        tbl[2] = 5'b1_1_1_1_1;
        tbl[3] = 5'b1_0_1_0_1;
        tbl[4] = 5'b0_1_0_0_0;
        tbl[5] = 5'b1_1_0_0_0;
        tbl[6] = 5'b1_1_1_1_1;
        tbl[7] = 5'b0_1_1_0_0;
        @(negedge CLK);
        clk_en = 0;
        for (int i = 0; i < 8; i++) begin
            bx = tbl[i][4]; by = tbl[i][3]; por = tbl[i][2];
            #1;
            checks++;
            if (pll_a !== tbl[i][1] || pll_b !== tbl[i][0]) begin
                errors++;
                $display("FAIL pll_step%0d: pll_a=%b pll_b=%b expected %b %b",
                         i, pll_a, pll_b, tbl[i][1], tbl[i][0]);
            end
        end
        checks++;
        if (fab_a !== 1'b0) begin
            errors++;
            $display("FAIL pll_fabric: fab_a=%b expected 0", fab_a);
        end
        clk_en = 1;
        all_good();
    endtask

    task automatic test_mid_release_pulse();
        settle_released();
        @(negedge CLK);
        ext = 0;
        #1 ext = 1;
        @(posedge CLK); #1;
        @(negedge CLK);
        #1 ext = 0;
        #1 ext = 1;
        #1;
        checks++;
        if (fab_a !== 1'b0) begin
            errors++;
            $display("FAIL pulse_assert: fab_a=%b expected 0", fab_a);
        end
        for (int e = 1; e <= 3; e++) begin
            @(posedge CLK); #1;
            checks++;
            if (fab_a !== (e >= 3)) begin
                errors++;
                $display("FAIL pulse_restart edge %0d: fab_a=%b expected %b", e, fab_a, e >= 3);
            end
        end
    endtask

    task automatic test_stages5();
        int na, nc;
        settle_released();
        @(negedge CLK);
        ext = 0;
        #1 ext = 1;
        for (int e = 1; e <= 5; e++) begin
            @(posedge CLK); #1;
            checks++;
            if (fab_c !== (e >= 5) || fab_a !== (e >= 3)) begin
                errors++;
                $display("FAIL stages5 edge %0d: fab_c=%b fab_a=%b expected %b %b",
                         e, fab_c, fab_a, e >= 5, e >= 3);
            end
        end
        @(negedge CLK);
        na = neg_a; nc = neg_c;
        ext = 0; por = 0;
        #1;
        checks++;
        if (fab_c !== 1'b0 || pll_c !== 1'b0 || neg_c - nc != 1 || neg_a - na != 1) begin
            errors++;
            $display("FAIL dual_assert: fab_c=%b pll_c=%b falls_c=%0d falls_a=%0d expected 0 0 1 1",
                     fab_c, pll_c, neg_c - nc, neg_a - na);
        end
        #1 ext = 1;
        #1 por = 1;
        repeat (5) @(posedge CLK);
        #1;
        checks++;
        if (fab_c !== 1'b1) begin
            errors++;
            $display("FAIL dual_release: fab_c=%b expected 1", fab_c);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            @(posedge CLK);
            #2;
            ext  = ($urandom_range(0, 15) != 0);
            lock = ($urandom_range(0, 15) != 0);
            init = ($urandom_range(0, 15) != 0);
            por  = ($urandom_range(0, 15) != 0);
            bx   = ($urandom_range(0, 15) != 0);
            by   = ($urandom_range(0, 15) != 0);
            ss   = ($urandom_range(0, 15) == 0);
            ff   = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 7) == 0) begin
                #1 ext = 0;
                #1 ext = 1;
            end
            @(negedge CLK);
            checks++;
            if (fab_a !== (cnt >= 3) || fab_c !== (cnt >= 5) ||
                pll_a !== m_pwr || pll_b !== m_pwr_noy) begin
                errors++;
                $display("FAIL random[%0d]: fab_a=%b fab_c=%b pll_a=%b pll_b=%b expected %b %b %b %b",
                         i, fab_a, fab_c, pll_a, pll_b, cnt >= 3, cnt >= 5, m_pwr, m_pwr_noy);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_async_assert(0);
        test_async_assert(1);
        test_async_assert(2);
        test_hold();
        test_pll();
        test_mid_release_pulse();
        test_stages5();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
